seven_segment_decoder: RTL and testbench

Receive-side counterpart of the hex-to-7-segment driver: samples an 8-bit segment bus, waits until the pattern has been stable for a programmable number of cycles, and decodes it back to a 4-bit hex digit. Each newly settled pattern is reported with a one-cycle strobe, and unknown patterns are counted. It sits on the display-readback / loopback path, used for self-test of the display driver and for monitoring externally driven displays.

---
 rtl/seven_segment_decoder_if.sv | 34 +++
 rtl/seven_segment_decoder.sv | 111 +++++++++++
 tb/tb_seven_segment_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_decoder_if.sv
// Segment readback bus: raw segment input, error clear and decoded results.
// The master drives the bus and clear; the slave (decoder) drives results.
interface seven_segment_decoder_if;
    logic [7:0] seg_in;
    logic       err_clr;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_dp;
    logic       out_blank;
    logic       out_illegal;
    logic [7:0] err_count;

    modport master (
        output seg_in,
        output err_clr,
        input  out_valid,
        input  out_digit,
        input  out_dp,
        input  out_blank,
        input  out_illegal,
        input  err_count
    );

    modport slave (
        input  seg_in,
        input  err_clr,
        output out_valid,
        output out_digit,
        output out_dp,
        output out_blank,
        output out_illegal,
        output err_count
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// Debounced 7-segment readback decoder: waits for a stable pattern,
// decodes it to a hex digit, pulses on change and counts illegal codes.
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_segment_decoder_if.slave  bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_PRE = CW'(STABLE_CYCLES - 1);

    logic [7:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_last;
    logic          r_have_last;
    logic          r_out_valid;
    logic [3:0]    r_out_digit;
    logic          r_out_dp;
    logic          r_out_blank;
    logic          r_out_illegal;
    logic [7:0]    r_err_count;

    logic          w_same;
    logic          w_accept;
    logic          w_new;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic          w_illegal;

    assign w_same   = (bus.seg_in == r_cand);
    assign w_accept = w_same && (r_cnt == C_PRE);
    assign w_new    = w_accept && (!r_have_last || (r_cand != r_last));

    // Decode the candidate's a..g segments; dp plays no part in the digit.
    always_comb begin
        w_digit   = 4'h0;
        w_blank   = 1'b0;
        w_illegal = 1'b0;
        case (r_cand[7:1])
            7'h7E:   w_digit = 4'h0;
            7'h30:   w_digit = 4'h1;
            7'h6D:   w_digit = 4'h2;
            7'h79:   w_digit = 4'h3;
            7'h33:   w_digit = 4'h4;
            7'h5B:   w_digit = 4'h5;
            7'h5F:   w_digit = 4'h6;
            7'h70:   w_digit = 4'h7;
            7'h7F:   w_digit = 4'h8;
            7'h7B:   w_digit = 4'h9;
            7'h77:   w_digit = 4'hA;
            7'h1F:   w_digit = 4'hB;
            7'h4E:   w_digit = 4'hC;
            7'h3D:   w_digit = 4'hD;
            7'h4F:   w_digit = 4'hE;
            7'h47:   w_digit = 4'hF;
            7'h00:   w_blank = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    // Stability counter, acceptance, result registers and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand        <= 8'h00;
            r_cnt         <= '0;
            r_last        <= 8'h00;
            r_have_last   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_digit   <= 4'h0;
            r_out_dp      <= 1'b0;
            r_out_blank   <= 1'b0;
            r_out_illegal <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            r_out_valid <= 1'b0;
            if (!w_same) begin
                r_cand <= bus.seg_in;
                r_cnt  <= CW'(1);
            end else if (r_cnt < C_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_new) begin
                r_last        <= r_cand;
                r_have_last   <= 1'b1;
                r_out_valid   <= 1'b1;
                r_out_digit   <= w_digit;
                r_out_dp      <= r_cand[0];
                r_out_blank   <= w_blank;
                r_out_illegal <= w_illegal;
                if (w_illegal && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'h01;
                end
            end
            // A clear request overrides any increment on the same edge.
            if (bus.err_clr) begin
                r_err_count <= 8'h00;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_digit   = r_out_digit;
    assign bus.out_dp      = r_out_dp;
    assign bus.out_blank   = r_out_blank;
    assign bus.out_illegal = r_out_illegal;
    assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder.
// Each step drives seg_in just after a rising edge and samples 1 ns later.
module tb_seven_segment_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   consec;
    logic prev_v;
    int   pulses;
    int   first;

    logic [7:0] codes [16];

    seven_segment_decoder_if sif ();

    seven_segment_decoder #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sif.out_valid && prev_v) consec++;
        prev_v = sif.out_valid;
    endtask

    task automatic hold(input logic [7:0] p, input int n,
                        output int np, output int fi);
        sif.seg_in = p;
        np = 0;
        fi = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (sif.out_valid) begin
                np++;
                if (fi == 0) fi = i;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        consec   = 0;
        prev_v   = 1'b0;
        codes = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                  8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        sif.seg_in  = 8'h00;
        sif.err_clr = 1'b0;
        rst         = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid",   sif.out_valid,   0);
        chk("rst_digit",   sif.out_digit,   0);
        chk("rst_dp",      sif.out_dp,      0);
        chk("rst_blank",   sif.out_blank,   0);
        chk("rst_illegal", sif.out_illegal, 0);
        chk("rst_err",     sif.err_count,   0);

        // Blank bus after reset counts from zero: pulse on 4th edge
        rst = 1'b0;
        hold(8'h00, 8, pulses, first);
        chk("blank_pulses",  pulses,          1);
        chk("blank_first",   first,           4);
        chk("blank_blank",   sif.out_blank,   1);
        chk("blank_digit",   sif.out_digit,   0);
        chk("blank_illegal", sif.out_illegal, 0);

        // 0xFC after reset: pulse 4 edges after the change
        do_reset();
        hold(8'hFC, 8, pulses, first);
        chk("fc_pulses",  pulses,          1);
        chk("fc_first",   first,           4);
        chk("fc_digit",   sif.out_digit,   0);
        chk("fc_dp",      sif.out_dp,      0);
        chk("fc_blank",   sif.out_blank,   0);
        chk("fc_illegal", sif.out_illegal, 0);

        // Sweep all 16 codes from a fresh reset
        do_reset();
        for (int k = 0; k < 16; k++) begin
            hold(codes[k], 6, pulses, first);
            chk($sformatf("sweep%0d_pulses", k), pulses, 1);
            chk($sformatf("sweep%0d_digit", k), sif.out_digit, k);
            chk($sformatf("sweep%0d_illegal", k), sif.out_illegal, 0);
        end

        // dp set: 0x61 -> digit 1, dp 1
        hold(8'h61, 6, pulses, first);
        chk("dp_pulses", pulses,        1);
        chk("dp_digit",  sif.out_digit, 1);
        chk("dp_dp",     sif.out_dp,    1);

        // Differing only in dp is a new pattern
        hold(8'h60, 6, pulses, first);
        chk("nodp_pulses", pulses,     1);
        chk("nodp_dp",     sif.out_dp, 0);

        // Glitch to 0xDA for 3 cycles and back: no report at all
        hold(8'hDA, 3, pulses, first);
        chk("glitch_pulses", pulses, 0);
        hold(8'h60, 8, pulses, first);
        chk("return_pulses", pulses,        0);
        chk("return_digit",  sif.out_digit, 1);

        // Illegal pattern g-only
        hold(8'h02, 6, pulses, first);
        chk("ill_pulses",  pulses,          1);
        chk("ill_illegal", sif.out_illegal, 1);
        chk("ill_digit",   sif.out_digit,   0);
        chk("ill_blank",   sif.out_blank,   0);
        chk("ill_err",     sif.err_count,   1);

        // Alternate legal/illegal 300 times: saturates at 255
        for (int k = 0; k < 300; k++) begin
            hold(8'h60, 5, pulses, first);
            hold(8'h02, 5, pulses, first);
        end
        chk("sat_err", sif.err_count, 255);
        hold(8'h60, 5, pulses, first);
        chk("sat_legal_illegal", sif.out_illegal, 0);

        // err_clr on the same edge as an illegal acceptance
        sif.seg_in = 8'h02;
        tick();
        tick();
        tick();
        chk("pre_clr_err", sif.err_count, 255);
        sif.err_clr = 1'b1;
        tick();
        sif.err_clr = 1'b0;
        chk("clr_valid",   sif.out_valid,   1);
        chk("clr_illegal", sif.out_illegal, 1);
        chk("clr_err",     sif.err_count,   0);
        hold(8'h02, 4, pulses, first);
        chk("clr_hold_err", sif.err_count, 0);

        // Reset mid-count discards progress and last pattern
        hold(8'h66, 6, pulses, first);
        chk("pre_rst_digit", sif.out_digit, 4);
        hold(8'hB6, 2, pulses, first);
        chk("pre_rst_pulses", pulses, 0);
        sif.seg_in = 8'h66;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",   sif.out_valid,   0);
        chk("mid_rst_digit",   sif.out_digit,   0);
        chk("mid_rst_illegal", sif.out_illegal, 0);
        chk("mid_rst_err",     sif.err_count,   0);
        hold(8'h66, 8, pulses, first);
        chk("post_rst_pulses", pulses,        1);
        chk("post_rst_first",  first,         4);
        chk("post_rst_digit",  sif.out_digit, 4);

        chk("no_back_to_back", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
